// File: rtl/receive_chars_pkg.sv
// Shared definitions for the line receiver and the character sender:
// FSM state encoding and the control-character codes both sides agree on.
package receive_chars_pkg;

  // Receiver FSM states, 3-bit encoding kept as plain constants so older
  // blocks that compare raw state values keep working.
  localparam logic [2:0] ST_IDLE          = 3'd0;
  localparam logic [2:0] ST_DECODE        = 3'd1;
  localparam logic [2:0] ST_WRITE         = 3'd2;
  localparam logic [2:0] ST_DONE          = 3'd3;
  localparam logic [2:0] ST_WAIT_TX_START = 3'd4;
  localparam logic [2:0] ST_WAIT_TX_END   = 3'd5;

  // Control characters; the sender's newline logic uses the same values.
  localparam logic [7:0] CR_CHAR = 8'h0D;
  localparam logic [7:0] LF_CHAR = 8'h0A;
  localparam logic [7:0] BS_CHAR = 8'h08;

  // Default geometry: 32 printable characters, 6-bit address/count so
  // addresses 32/33 remain free for the sender's LF/CR.
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_MAX_CHARS  = 32;

  // Classification of the byte currently being decoded.
  typedef enum logic [1:0] {
    CHAR_PRINTABLE = 2'd0,
    CHAR_CR        = 2'd1,
    CHAR_BS        = 2'd2,
    CHAR_LF        = 2'd3
  } char_class_e;

endpackage

// File: rtl/receive_chars_if.sv
// Bus between the line receiver and its surroundings: the UART rx FIFO
// handshake, the sender busy flag, and the RAM write port / line result.
interface receive_chars_if
  import receive_chars_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  rx_empty;
  logic [7:0]            rx_data;
  logic                  Transmitting;
  logic                  read_uart;
  logic [ADDR_WIDTH-1:0] RAMAddress;
  logic [7:0]            RAMData;
  logic                  RAMWrite;
  logic [ADDR_WIDTH-1:0] NumberOfChars;
  logic                  LineDone;

  // The receiver itself.
  modport master (
    input  rx_empty, rx_data, Transmitting,
    output read_uart, RAMAddress, RAMData, RAMWrite, NumberOfChars, LineDone
  );

  // FIFO, RAM and sender side.
  modport slave (
    output rx_empty, rx_data, Transmitting,
    input  read_uart, RAMAddress, RAMData, RAMWrite, NumberOfChars, LineDone
  );

endinterface

// File: rtl/receive_chars.sv
// Line receiver: pops bytes from the UART rx FIFO, stores printable ones at
// consecutive RAM addresses, handles backspace, and on CR publishes the line
// length and pulses LineDone to start the echo. It then waits for the echo
// transmission to finish before reading the FIFO again.
module receive_chars
  import receive_chars_pkg::*;
#(
  parameter int         ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int         MAX_CHARS  = DEFAULT_MAX_CHARS,
  parameter logic [7:0] CR_CODE    = CR_CHAR,
  parameter logic [7:0] LF_CODE    = LF_CHAR,
  parameter logic [7:0] BS_CODE    = BS_CHAR
) (
  input logic             Clock,
  input logic             Reset,
  receive_chars_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(MAX_CHARS);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] count;
  logic [7:0]            char_q;
  char_class_e           char_class;

  // Classify the captured byte; CR wins over BS, BS over LF.
  always_comb begin
    char_class = CHAR_PRINTABLE;
    if (char_q == CR_CODE) begin
      char_class = CHAR_CR;
    end else if (char_q == BS_CODE) begin
      char_class = CHAR_BS;
    end else if (char_q == LF_CODE) begin
      char_class = CHAR_LF;
    end
  end

  // Main FSM: every output is a register; reset clears the partial line.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state             <= ST_IDLE;
      count             <= '0;
      char_q            <= '0;
      bus.read_uart     <= 1'b0;
      bus.RAMWrite      <= 1'b0;
      bus.LineDone      <= 1'b0;
      bus.RAMAddress    <= '0;
      bus.RAMData       <= '0;
      bus.NumberOfChars <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.rx_empty && !bus.Transmitting) begin
            char_q        <= bus.rx_data;
            bus.read_uart <= 1'b1;
            state         <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          bus.read_uart <= 1'b0;
          case (char_class)
            CHAR_CR: begin
              state <= (count == '0) ? ST_IDLE : ST_DONE;
            end
            CHAR_BS: begin
              if (count != '0) begin
                count <= count - ONE;
              end
              state <= ST_IDLE;
            end
            CHAR_LF: begin
              state <= ST_IDLE;
            end
            default: begin
              if (count == FULL_COUNT) begin
                state <= ST_IDLE;
              end else begin
                bus.RAMAddress <= count;
                bus.RAMData    <= char_q;
                bus.RAMWrite   <= 1'b1;
                state          <= ST_WRITE;
              end
            end
          endcase
        end

        ST_WRITE: begin
          bus.RAMWrite <= 1'b0;
          count        <= count + ONE;
          state        <= ST_IDLE;
        end

        ST_DONE: begin
          bus.NumberOfChars <= count;
          bus.LineDone      <= 1'b1;
          count             <= '0;
          state             <= ST_WAIT_TX_START;
        end

        ST_WAIT_TX_START: begin
          bus.LineDone <= 1'b0;
          if (bus.Transmitting) begin
            state <= ST_WAIT_TX_END;
          end
        end

        ST_WAIT_TX_END: begin
          if (!bus.Transmitting) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          bus.read_uart <= 1'b0;
          bus.RAMWrite  <= 1'b0;
          bus.LineDone  <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receive_chars.sv
// Directed bench for the line receiver: a queue models the UART rx FIFO,
// a negedge monitor logs RAM writes and LineDone pulses, and each test task
// compares the logs against hand-computed values.
module tb_receive_chars;

  logic Clock;
  logic Reset;

  receive_chars_if bus ();

  receive_chars dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int testCount = 0;
  int failCount = 0;

  logic [7:0] fifo [$];
  logic [5:0] wrAddrLog [$];
  logic [7:0] wrDataLog [$];
  int         lineDoneCount = 0;
  int         cycleCount = 0;
  int         firstPopCycle = -1;
  int         lineDoneCycle = -1;
  logic [5:0] maxAddr = '0;

  // Free-running clock, 10 time units per period.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // FIFO model: a pop strobe visible at negedge consumes the head byte;
  // flags are refreshed away from the DUT's sampling edge.
  always @(negedge Clock) begin
    if (bus.read_uart && fifo.size() > 0) begin
      void'(fifo.pop_front());
    end
    bus.rx_empty = (fifo.size() == 0);
    bus.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Monitor: log RAM writes, LineDone pulses and timing markers.
  always @(negedge Clock) begin
    cycleCount++;
    if (bus.RAMWrite) begin
      wrAddrLog.push_back(bus.RAMAddress);
      wrDataLog.push_back(bus.RAMData);
      if (bus.RAMAddress > maxAddr) maxAddr = bus.RAMAddress;
    end
    if (bus.LineDone) begin
      lineDoneCount++;
      lineDoneCycle = cycleCount;
    end
    if (bus.read_uart && firstPopCycle < 0) firstPopCycle = cycleCount;
  end

  task automatic applyStimulus(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic clearLogs();
    wrAddrLog.delete();
    wrDataLog.delete();
    lineDoneCount = 0;
    firstPopCycle = -1;
    lineDoneCycle = -1;
  endtask

  task automatic waitLineDone(input int budget);
    int n = 0;
    while (!bus.LineDone && n < budget) begin
      @(negedge Clock);
      n++;
    end
    testCount++;
    if (!bus.LineDone) begin
      failCount++;
      $display("[TB] FAIL line_done_timeout: got no LineDone, expected one within %0d cycles", budget);
    end
  endtask

  task automatic echoTransmit(input int cycles);
    @(negedge Clock);
    bus.Transmitting = 1'b1;
    repeat (cycles) @(negedge Clock);
    bus.Transmitting = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic drainIdle(input int budget);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    repeat (4) @(negedge Clock);
    testCount++;
    if (fifo.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain_timeout: got %0d bytes left, expected 0", fifo.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Transmitting = 1'b0;
    repeat (2) @(negedge Clock);
    testCount++;
    if (bus.read_uart !== 1'b0) begin failCount++; $display("[TB] FAIL reset_read_uart: got %b expected 0", bus.read_uart); end
    testCount++;
    if (bus.RAMWrite !== 1'b0) begin failCount++; $display("[TB] FAIL reset_RAMWrite: got %b expected 0", bus.RAMWrite); end
    testCount++;
    if (bus.LineDone !== 1'b0) begin failCount++; $display("[TB] FAIL reset_LineDone: got %b expected 0", bus.LineDone); end
    testCount++;
    if (bus.RAMAddress !== 6'd0) begin failCount++; $display("[TB] FAIL reset_RAMAddress: got %0d expected 0", bus.RAMAddress); end
    testCount++;
    if (bus.RAMData !== 8'h00) begin failCount++; $display("[TB] FAIL reset_RAMData: got %h expected 00", bus.RAMData); end
    testCount++;
    if (bus.NumberOfChars !== 6'd0) begin failCount++; $display("[TB] FAIL reset_NumberOfChars: got %0d expected 0", bus.NumberOfChars); end
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    testCount++;
    if (bus.read_uart !== 1'b0) begin failCount++; $display("[TB] FAIL idle_empty_no_pop: got %b expected 0", bus.read_uart); end
  endtask

  task automatic test_basic_line();
    logic [7:0] expD [3];
    logic [5:0] gotA;
    logic [7:0] gotD;
    expD = '{8'h41, 8'h42, 8'h43};
    clearLogs();
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    applyStimulus(8'h0D);
    waitLineDone(100);
    @(negedge Clock);
    bus.Transmitting = 1'b1;
    repeat (5) @(negedge Clock);
    testCount++;
    if (bus.NumberOfChars !== 6'd3) begin failCount++; $display("[TB] FAIL basic_count_during_tx: got %0d expected 3", bus.NumberOfChars); end
    bus.Transmitting = 1'b0;
    repeat (3) @(negedge Clock);
    testCount++;
    if (wrAddrLog.size() != 3) begin failCount++; $display("[TB] FAIL basic_write_count: got %0d expected 3", wrAddrLog.size()); end
    for (int i = 0; i < 3; i++) begin
      gotA = (i < wrAddrLog.size()) ? wrAddrLog[i] : 6'bx;
      gotD = (i < wrDataLog.size()) ? wrDataLog[i] : 8'bx;
      testCount++;
      if (gotA !== 6'(i) || gotD !== expD[i]) begin
        failCount++;
        $display("[TB] FAIL basic_write%0d: got addr %0d data %h expected addr %0d data %h", i, gotA, gotD, i, expD[i]);
      end
    end
    testCount++;
    if (bus.NumberOfChars !== 6'd3) begin failCount++; $display("[TB] FAIL basic_NumberOfChars: got %0d expected 3", bus.NumberOfChars); end
    testCount++;
    if (lineDoneCount != 1) begin failCount++; $display("[TB] FAIL basic_LineDone_pulses: got %0d expected 1", lineDoneCount); end
    testCount++;
    if (lineDoneCycle - firstPopCycle != 11) begin failCount++; $display("[TB] FAIL basic_latency: got %0d expected 11", lineDoneCycle - firstPopCycle); end
  endtask

  task automatic test_backspace();
    logic [5:0] expA [3];
    logic [7:0] expD [3];
    logic [5:0] gotA;
    logic [7:0] gotD;
    expA = '{6'd0, 6'd1, 6'd1};
    expD = '{8'h41, 8'h42, 8'h43};
    clearLogs();
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h08);
    applyStimulus(8'h43);
    applyStimulus(8'h0D);
    waitLineDone(100);
    echoTransmit(5);
    testCount++;
    if (wrAddrLog.size() != 3) begin failCount++; $display("[TB] FAIL bs_write_count: got %0d expected 3", wrAddrLog.size()); end
    for (int i = 0; i < 3; i++) begin
      gotA = (i < wrAddrLog.size()) ? wrAddrLog[i] : 6'bx;
      gotD = (i < wrDataLog.size()) ? wrDataLog[i] : 8'bx;
      testCount++;
      if (gotA !== expA[i] || gotD !== expD[i]) begin
        failCount++;
        $display("[TB] FAIL bs_write%0d: got addr %0d data %h expected addr %0d data %h", i, gotA, gotD, expA[i], expD[i]);
      end
    end
    testCount++;
    if (bus.NumberOfChars !== 6'd2) begin failCount++; $display("[TB] FAIL bs_NumberOfChars: got %0d expected 2", bus.NumberOfChars); end
  endtask

  task automatic test_empty_controls();
    clearLogs();
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    applyStimulus(8'h0A);
    drainIdle(50);
    testCount++;
    if (wrAddrLog.size() != 0) begin failCount++; $display("[TB] FAIL empty_no_write: got %0d writes expected 0", wrAddrLog.size()); end
    testCount++;
    if (lineDoneCount != 0) begin failCount++; $display("[TB] FAIL empty_no_linedone: got %0d expected 0", lineDoneCount); end
    testCount++;
    if (bus.NumberOfChars !== 6'd2) begin failCount++; $display("[TB] FAIL empty_count_held: got %0d expected 2", bus.NumberOfChars); end
    applyStimulus(8'h58);
    applyStimulus(8'h0D);
    waitLineDone(50);
    echoTransmit(4);
    testCount++;
    if (wrAddrLog.size() != 1 || wrAddrLog[0] !== 6'd0 || wrDataLog[0] !== 8'h58) begin
      failCount++;
      $display("[TB] FAIL empty_next_char_addr0: got %0d writes, expected one write addr 0 data 58", wrAddrLog.size());
    end
    testCount++;
    if (bus.NumberOfChars !== 6'd1) begin failCount++; $display("[TB] FAIL empty_next_NumberOfChars: got %0d expected 1", bus.NumberOfChars); end
  endtask

  task automatic test_saturate();
    logic [5:0] expA;
    logic [7:0] expD;
    logic [5:0] gotA;
    logic [7:0] gotD;
    clearLogs();
    maxAddr = '0;
    for (int i = 0; i < 35; i++) applyStimulus(8'(8'h41 + i));
    applyStimulus(8'h08);
    applyStimulus(8'h7A);
    applyStimulus(8'h0D);
    waitLineDone(300);
    echoTransmit(4);
    testCount++;
    if (wrAddrLog.size() != 33) begin failCount++; $display("[TB] FAIL sat_write_count: got %0d expected 33", wrAddrLog.size()); end
    for (int i = 0; i < 33; i++) begin
      expA = (i < 32) ? 6'(i) : 6'd31;
      expD = (i < 32) ? 8'(8'h41 + i) : 8'h7A;
      gotA = (i < wrAddrLog.size()) ? wrAddrLog[i] : 6'bx;
      gotD = (i < wrDataLog.size()) ? wrDataLog[i] : 8'bx;
      testCount++;
      if (gotA !== expA || gotD !== expD) begin
        failCount++;
        $display("[TB] FAIL sat_write%0d: got addr %0d data %h expected addr %0d data %h", i, gotA, gotD, expA, expD);
      end
    end
    testCount++;
    if (maxAddr !== 6'd31) begin failCount++; $display("[TB] FAIL sat_max_addr: got %0d expected 31", maxAddr); end
    testCount++;
    if (bus.NumberOfChars !== 6'd32) begin failCount++; $display("[TB] FAIL sat_NumberOfChars: got %0d expected 32", bus.NumberOfChars); end
  endtask

  task automatic test_tx_holdoff();
    logic sawPop;
    clearLogs();
    applyStimulus(8'h41);
    applyStimulus(8'h0D);
    waitLineDone(50);
    applyStimulus(8'h08);
    repeat (2) @(negedge Clock);
    bus.Transmitting = 1'b1;
    sawPop = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (bus.read_uart) sawPop = 1'b1;
    end
    testCount++;
    if (sawPop !== 1'b0) begin failCount++; $display("[TB] FAIL holdoff_no_pop: got pop=%b expected 0", sawPop); end
    testCount++;
    if (fifo.size() != 1) begin failCount++; $display("[TB] FAIL holdoff_byte_queued: got %0d expected 1", fifo.size()); end
    testCount++;
    if (bus.NumberOfChars !== 6'd1) begin failCount++; $display("[TB] FAIL holdoff_NumberOfChars: got %0d expected 1", bus.NumberOfChars); end
    bus.Transmitting = 1'b0;
    @(negedge Clock);
    testCount++;
    if (bus.read_uart !== 1'b0) begin failCount++; $display("[TB] FAIL holdoff_early_pop: got %b expected 0", bus.read_uart); end
    @(negedge Clock);
    testCount++;
    if (bus.read_uart !== 1'b1) begin failCount++; $display("[TB] FAIL holdoff_resume_pop: got %b expected 1", bus.read_uart); end
    drainIdle(20);
    testCount++;
    if (lineDoneCount != 1) begin failCount++; $display("[TB] FAIL holdoff_LineDone_pulses: got %0d expected 1", lineDoneCount); end
  endtask

  task automatic test_reset_midline();
    int n = 0;
    clearLogs();
    applyStimulus(8'h58);
    applyStimulus(8'h59);
    applyStimulus(8'h57);
    @(negedge Clock);
    while (!(bus.RAMWrite && bus.RAMAddress == 6'd1) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    testCount++;
    if (!(bus.RAMWrite && bus.RAMAddress == 6'd1)) begin failCount++; $display("[TB] FAIL mid_second_write_timeout: got no write to addr 1, expected one"); end
    #1 Reset = 1'b0;
    #1;
    testCount++;
    if (bus.RAMWrite !== 1'b0 || bus.read_uart !== 1'b0 || bus.LineDone !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mid_strobes_async: got RAMWrite %b read_uart %b LineDone %b expected 0 0 0", bus.RAMWrite, bus.read_uart, bus.LineDone);
    end
    testCount++;
    if (bus.RAMAddress !== 6'd0 || bus.RAMData !== 8'h00 || bus.NumberOfChars !== 6'd0) begin
      failCount++;
      $display("[TB] FAIL mid_outputs_async: got addr %0d data %h chars %0d expected 0 00 0", bus.RAMAddress, bus.RAMData, bus.NumberOfChars);
    end
    fifo.delete();
    @(negedge Clock);
    Reset = 1'b1;
    clearLogs();
    applyStimulus(8'h5A);
    applyStimulus(8'h0D);
    waitLineDone(50);
    echoTransmit(4);
    testCount++;
    if (wrAddrLog.size() != 1 || wrAddrLog[0] !== 6'd0 || wrDataLog[0] !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL mid_new_line_write: got %0d writes, expected one write addr 0 data 5A", wrAddrLog.size());
    end
    testCount++;
    if (bus.NumberOfChars !== 6'd1) begin failCount++; $display("[TB] FAIL mid_NumberOfChars: got %0d expected 1", bus.NumberOfChars); end
    testCount++;
    if (lineDoneCount != 1) begin failCount++; $display("[TB] FAIL mid_LineDone_pulses: got %0d expected 1", lineDoneCount); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic_line();
    test_backspace();
    test_empty_controls();
    test_saturate();
    test_tx_holdoff();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
